// File: rtl/pc_gen_unit.sv
// pc_gen_unit: next-PC generator that sits ahead of the fetch stage.
//
// Arbitrates NUM_REDIR prioritised redirect channels (index 0 wins), a branch
// predictor target and the sequential increment. A redirect that arrives
// while the pipeline is stalled is buffered and applied once the stall
// drops. Every applied redirect bumps a wrapping epoch tag so fetch can
// discard wrong-path responses.
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-low reset
//   redir_valid_i  per-channel redirect request, [NUM_REDIR-1:0]
//   redir_pc_i     redirect targets, channel k at [k*PC_W +: PC_W]
//   pred_valid_i   predictor target valid for the current pc_o
//   pred_pc_i      predicted next PC
//   stall_i        pipeline freeze
//   pc_ready_i     fetch accepts pc_o
//   pc_valid_o     pc_o valid to fetch (combinational)
//   pc_o           current fetch PC
//   epoch_o        redirect epoch tag for pc_o
//   pend_o         a redirect is buffered
//   misalign_o     (PC_GEN_MISALIGN_CHECK_EN only) redirect/predictor loaded
//                  a PC with pc[1:0] != 0
//
// Optional feature macro: PC_GEN_MISALIGN_CHECK_EN

module pc_gen_unit #(
    parameter int unsigned PC_W       = 64,
    parameter int unsigned NUM_REDIR  = 2,
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int unsigned INST_BYTES = 4,
    parameter int unsigned EPOCH_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REDIR-1:0]      redir_valid_i,
    input  logic [NUM_REDIR*PC_W-1:0] redir_pc_i,
    input  logic                      pred_valid_i,
    input  logic [PC_W-1:0]           pred_pc_i,
    input  logic                      stall_i,
    input  logic                      pc_ready_i,
    output logic                      pc_valid_o,
    output logic [PC_W-1:0]           pc_o,
    output logic [EPOCH_W-1:0]        epoch_o,
    output logic                      pend_o
`ifdef PC_GEN_MISALIGN_CHECK_EN
    ,
    output logic                      misalign_o
`endif
);

    localparam int unsigned    IDX_W  = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;
    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    logic [1:0]         state_q,    state_d;
    logic [PC_W-1:0]    pc_q,       pc_d;
    logic [EPOCH_W-1:0] epoch_q,    epoch_d;
    logic               pend_v_q,   pend_v_d;
    logic [IDX_W-1:0]   pend_idx_q, pend_idx_d;
    logic [PC_W-1:0]    pend_pc_q,  pend_pc_d;

    logic               win_any;
    logic [IDX_W-1:0]   win_idx;
    logic [PC_W-1:0]    win_pc;
    logic               fire;
    logic               capture;
    logic               load;
    logic               load_chk;

    // Lowest-index asserted channel wins.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        win_pc  = '0;
        for (int unsigned k = 0; k < NUM_REDIR; k++) begin
            if (redir_valid_i[k] && !win_any) begin
                win_any = 1'b1;
                win_idx = IDX_W'(k);
                win_pc  = redir_pc_i[k*PC_W +: PC_W];
            end
        end
    end

    assign pc_valid_o = (state_q != ST_BOOT) && !stall_i;
    assign fire       = pc_valid_o && pc_ready_i;

    // An incoming redirect takes over the buffer only if it is at least as
    // old (same or lower index) as the one already held.
    assign capture = win_any && (!pend_v_q || (win_idx <= pend_idx_q));

    always_comb begin
        pc_d       = pc_q;
        epoch_d    = epoch_q;
        pend_v_d   = pend_v_q;
        pend_idx_d = pend_idx_q;
        pend_pc_d  = pend_pc_q;
        load       = 1'b0;
        load_chk   = 1'b0;

        if ((state_q == ST_BOOT) || stall_i) begin
            if (capture) begin
                pend_v_d   = 1'b1;
                pend_idx_d = win_idx;
                pend_pc_d  = win_pc;
            end
        end else if (pend_v_q) begin
            // A redirect captured during BOOT is drained here from RUN just
            // like one drained when leaving PEND.
            pc_d     = (win_any && (win_idx < pend_idx_q)) ? win_pc : pend_pc_q;
            epoch_d  = epoch_q + EPOCH_W'(1);
            pend_v_d = 1'b0;
            load     = 1'b1;
            load_chk = 1'b1;
        end else if (win_any) begin
            pc_d     = win_pc;
            epoch_d  = epoch_q + EPOCH_W'(1);
            load     = 1'b1;
            load_chk = 1'b1;
        end else if (fire) begin
            pc_d     = pred_valid_i ? pred_pc_i : (pc_q + PC_W'(INST_BYTES));
            load     = 1'b1;
            load_chk = pred_valid_i;
        end

        if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
        end else if (stall_i && pend_v_d) begin
            state_d = ST_PEND;
        end else begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RST_PC;
            epoch_q    <= '0;
            pend_v_q   <= 1'b0;
            pend_idx_q <= '0;
            pend_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epoch_q    <= epoch_d;
            pend_v_q   <= pend_v_d;
            pend_idx_q <= pend_idx_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    assign pc_o    = pc_q;
    assign epoch_o = epoch_q;
    assign pend_o  = pend_v_q;

`ifdef PC_GEN_MISALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else if (load) begin
            misalign_q <= load_chk && (pc_d[1:0] != 2'b00);
        end
    end

    assign misalign_o = misalign_q;
`else
    logic unused_chk;
    assign unused_chk = load ^ load_chk;
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// Testbench for pc_gen_unit: directed test-plan sequences plus a random
// phase, each cycle's expected outputs queued from a behavioural model and
// popped once the DUT has clocked.

module tb_pc_gen_unit;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic         clk;
    logic         rst;
    logic [1:0]   redir_valid_i;
    logic [127:0] redir_pc_i;
    logic         pred_valid_i;
    logic [63:0]  pred_pc_i;
    logic         stall_i;
    logic         pc_ready_i;
    logic         pc_valid_o;
    logic [63:0]  pc_o;
    logic [2:0]   epoch_o;
    logic         pend_o;
`ifdef PC_GEN_MISALIGN_CHECK_EN
    logic         misalign_o;
`endif

    pc_gen_unit #(
        .PC_W       (64),
        .NUM_REDIR  (2),
        .RESET_PC   (RST_PC),
        .INST_BYTES (4),
        .EPOCH_W    (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redir_valid_i (redir_valid_i),
        .redir_pc_i    (redir_pc_i),
        .pred_valid_i  (pred_valid_i),
        .pred_pc_i     (pred_pc_i),
        .stall_i       (stall_i),
        .pc_ready_i    (pc_ready_i),
        .pc_valid_o    (pc_valid_o),
        .pc_o          (pc_o),
        .epoch_o       (epoch_o),
        .pend_o        (pend_o)
`ifdef PC_GEN_MISALIGN_CHECK_EN
        ,
        .misalign_o    (misalign_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [2:0]  ep;
        logic        pend;
        logic        valid;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_boot;
    logic [63:0] m_pc;
    logic [2:0]  m_ep;
    bit          m_pv;
    int          m_pidx;
    logic [63:0] m_ppc;
    bit          m_mis;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1;
        m_pc   = RST_PC;
        m_ep   = 3'd0;
        m_pv   = 1'b0;
        m_pidx = 0;
        m_ppc  = '0;
        m_mis  = 1'b0;
        exp_q.delete();
    endtask

    task automatic set_redir(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1);
        redir_valid_i     = v;
        redir_pc_i[63:0]  = p0;
        redir_pc_i[127:64] = p1;
    endtask

    // Advance one clock: model predicts, pushes, DUT clocks, compare on pop.
    task automatic step(input string tag);
        exp_t        e;
        bit          w_any;
        int          w_idx;
        logic [63:0] w_pc;

        w_any = 1'b0;
        w_idx = 0;
        w_pc  = '0;
        for (int k = 1; k >= 0; k--) begin
            if (redir_valid_i[k]) begin
                w_any = 1'b1;
                w_idx = k;
                w_pc  = redir_pc_i[k*64 +: 64];
            end
        end

        if (m_boot || stall_i) begin
            if (w_any && (!m_pv || w_idx <= m_pidx)) begin
                m_pv   = 1'b1;
                m_pidx = w_idx;
                m_ppc  = w_pc;
            end
            m_boot = 1'b0;
        end else if (m_pv) begin
            m_pc  = (w_any && w_idx < m_pidx) ? w_pc : m_ppc;
            m_ep  = m_ep + 3'd1;
            m_pv  = 1'b0;
            m_mis = (m_pc[1:0] != 2'b00);
        end else if (w_any) begin
            m_pc  = w_pc;
            m_ep  = m_ep + 3'd1;
            m_mis = (m_pc[1:0] != 2'b00);
        end else if (pc_ready_i) begin
            if (pred_valid_i) begin
                m_pc  = pred_pc_i;
                m_mis = (m_pc[1:0] != 2'b00);
            end else begin
                m_pc  = m_pc + 64'd4;
                m_mis = 1'b0;
            end
        end

        e.pc    = m_pc;
        e.ep    = m_ep;
        e.pend  = m_pv;
        e.valid = !m_boot && !stall_i;
        e.mis   = m_mis;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val({tag, ".pc"},    pc_o,       e.pc);
        check_val({tag, ".epoch"}, 64'(epoch_o), 64'(e.ep));
        check_val({tag, ".pend"},  64'(pend_o),  64'(e.pend));
        check_val({tag, ".valid"}, 64'(pc_valid_o), 64'(e.valid));
`ifdef PC_GEN_MISALIGN_CHECK_EN
        check_val({tag, ".mis"},   64'(misalign_o), 64'(e.mis));
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        set_redir(2'b00, '0, '0);
        pred_valid_i = 1'b0;
        pred_pc_i    = '0;
        stall_i      = 1'b0;
        pc_ready_i   = 1'b1;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst.pc",    pc_o, RST_PC);
        check_val("rst.epoch", 64'(epoch_o), 64'd0);
        check_val("rst.pend",  64'(pend_o), 64'd0);
        check_val("rst.valid", 64'(pc_valid_o), 64'd0);

        // Boot then sequential stepping
        rst = 1'b1;
        check_val("boot.valid", 64'(pc_valid_o), 64'd0);
        step("boot");
        check_val("seq0", pc_o, 64'h8000_0000);
        step("seq1");
        check_val("seq1.pc", pc_o, 64'h8000_0004);
        step("seq2");
        check_val("seq2.pc", pc_o, 64'h8000_0008);

        // Dual redirect, ch0 wins, not accepted by fetch
        pc_ready_i = 1'b0;
        set_redir(2'b11, 64'h8000_1000, 64'h8000_2000);
        step("redir");
        check_val("redir.pc", pc_o, 64'h8000_1000);
        check_val("redir.ep", 64'(epoch_o), 64'd1);
        set_redir(2'b00, '0, '0);
        pc_ready_i = 1'b1;

        // Redirects buffered during stall
        stall_i = 1'b1;
        set_redir(2'b10, '0, 64'h8000_2000);
        step("st1");
        set_redir(2'b01, 64'h8000_3000, '0);
        step("st2");
        set_redir(2'b10, '0, 64'h8000_4000);
        step("st3");
        check_val("st3.pc", pc_o, 64'h8000_1000);
        check_val("st3.pend", 64'(pend_o), 64'd1);
        set_redir(2'b00, '0, '0);
        stall_i = 1'b0;
        step("st_rel");
        check_val("st_rel.pc", pc_o, 64'h8000_3000);
        check_val("st_rel.ep", 64'(epoch_o), 64'd2);

        // Lower-index incoming redirect beats pending one at release
        stall_i = 1'b1;
        set_redir(2'b10, '0, 64'h8000_5000);
        step("ov1");
        stall_i = 1'b0;
        set_redir(2'b01, 64'h8000_6000, '0);
        step("ov2");
        check_val("ov2.pc", pc_o, 64'h8000_6000);
        check_val("ov2.ep", 64'(epoch_o), 64'd3);

        // Higher-index incoming redirect loses to pending at release
        stall_i = 1'b1;
        set_redir(2'b01, 64'h8000_7000, '0);
        step("ov3");
        stall_i = 1'b0;
        set_redir(2'b10, '0, 64'h8000_8000);
        step("ov4");
        check_val("ov4.pc", pc_o, 64'h8000_7000);
        set_redir(2'b00, '0, '0);

        // Predictor
        pred_valid_i = 1'b1;
        pred_pc_i    = 64'h8000_0100;
        step("pred1");
        check_val("pred1.pc", pc_o, 64'h8000_0100);
        pc_ready_i = 1'b0;
        pred_pc_i  = 64'h8000_0200;
        step("pred2");
        check_val("pred2.pc", pc_o, 64'h8000_0100);
        pred_valid_i = 1'b0;
        pc_ready_i   = 1'b1;

        // Increment wraps
        set_redir(2'b01, 64'hFFFF_FFFF_FFFF_FFFC, '0);
        step("wrap0");
        set_redir(2'b00, '0, '0);
        step("wrap1");
        check_val("wrap1.pc", pc_o, 64'd0);
        check_val("wrap1.ep", 64'(epoch_o), 64'(m_ep));

        // Async reset while a redirect is pending
        stall_i = 1'b1;
        set_redir(2'b01, 64'h8000_9000, '0);
        step("pr1");
        set_redir(2'b00, '0, '0);
        #2;
        rst = 1'b0;
        #1;
        check_val("arst.pc",   pc_o, RST_PC);
        check_val("arst.pend", 64'(pend_o), 64'd0);
        check_val("arst.valid", 64'(pc_valid_o), 64'd0);
        model_reset();
        stall_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("post_boot");
        check_val("post_boot.pc", pc_o, RST_PC);
        step("post1");
        check_val("post1.pc", pc_o, RST_PC + 64'd4);
        check_val("post1.ep", 64'(epoch_o), 64'd0);

`ifdef PC_GEN_MISALIGN_CHECK_EN
        set_redir(2'b01, 64'h8000_0002, '0);
        step("mis1");
        check_val("mis1.flag", 64'(misalign_o), 64'd1);
        set_redir(2'b00, '0, '0);
        step("mis2");
        check_val("mis2.flag", 64'(misalign_o), 64'd0);
`endif

        // Random phase
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                set_redir(2'($urandom_range(1, 3)),
                          {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)},
                          {32'h0, 32'h9000_0000 | ($urandom & 32'h0000_FFFF)});
            end else begin
                set_redir(2'b00, '0, '0);
            end
            stall_i      = ($urandom_range(0, 3) == 0);
            pc_ready_i   = ($urandom_range(0, 3) != 0);
            pred_valid_i = ($urandom_range(0, 3) == 0);
            pred_pc_i    = {32'h0, 32'hA000_0000 | ($urandom & 32'h0000_FFFF)};
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Parametrised next-PC generator; successor to the single-cycle PC register.
- Sits ahead of the fetch stage.
- Arbitrates NUM_REDIR prioritised redirect channels (EX, ID, ...), a branch-predictor target and sequential increment.
- Buffers a redirect that arrives during a stall, presents PC to fetch over a valid/ready handshake, and tags every redirect with a wrapping epoch so fetch can discard wrong-path responses.

Parameters:
- PC_W, 64, PC width in bits.
- NUM_REDIR, 2, number of redirect channels; index 0 has the highest priority (oldest stage).
- RESET_PC, 64'h0000_0000_8000_0000, PC presented after reset (truncated to PC_W).
- INST_BYTES, 4, sequential increment.
- EPOCH_W, 3, epoch tag width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- redir_valid_i  in  NUM_REDIR  per-channel redirect request
- redir_pc_i  in  NUM_REDIR*PC_W  redirect targets; channel k at bits [k*PC_W +: PC_W]
- pred_valid_i  in  1  predictor target valid for the current pc_o
- pred_pc_i  in  PC_W  predicted next PC
- stall_i  in  1  pipeline freeze
- pc_ready_i  in  1  fetch accepts pc_o
- pc_valid_o  out  1  pc_o valid to fetch
- pc_o  out  PC_W  current fetch PC
- epoch_o  out  EPOCH_W  redirect epoch tag for pc_o
- pend_o  out  1  redirect buffered during stall

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_o=RESET_PC, epoch_o=0, pending register cleared, pend_o=0, state=BOOT.
  - pc_valid_o is 0 while in reset.
  - Reset mid-operation discards any pending redirect.
- States:
  - BOOT: one cycle after reset release, pc_valid_o=0, then go to RUN unconditionally. Redirects in BOOT are captured as in PEND.
  - RUN: normal operation.
  - PEND: stall_i high with a captured redirect.
- pc_valid_o = (state != BOOT) & ~stall_i (combinational).
- fire = pc_valid_o & pc_ready_i.
- Winner: lowest index k with redir_valid_i[k]=1.
- RUN, stall_i=0, any redirect:
  - pc_o <= winner target next cycle, regardless of pc_ready_i (the unaccepted PC is wrong-path).
  - epoch_o <= epoch_o+1, wrapping modulo 2^EPOCH_W.
- RUN, stall_i=0, no redirect:
  - If fire: pc_o <= pred_valid_i ? pred_pc_i : pc_o+INST_BYTES.
  - Otherwise pc_o holds.
  - The increment wraps modulo 2^PC_W.
- RUN, stall_i=1:
  - pc_o and epoch_o hold.
  - A redirect is captured (target plus channel index) and the block goes to PEND with pend_o=1.
- PEND, stall_i=1:
  - A new redirect whose winner index is <= the stored index replaces the pending one.
  - A redirect with a higher index is ignored.
  - pc_o holds.
- PEND, stall_i=0:
  - pc_o <= pending target, unless an incoming redirect has a strictly lower index; then the incoming target is used.
  - epoch_o increments once.
  - Pending cleared, pend_o=0, state RUN.
- Predictor input is ignored in any cycle where a redirect or pending redirect is applied.
- Only one epoch increment per cycle, regardless of how many channels are asserted.
- Latency: redirect to new pc_o is 1 cycle when unstalled; 1 cycle after stall_i falls when stalled.

Optional Feature:
- Macro PC_GEN_MISALIGN_CHECK_EN.
- When defined:
  - Adds output misalign_o (1 bit), registered with pc_o.
  - misalign_o is set when the newly loaded pc_o has pc[1:0] != 0 and the load came from a redirect or predictor source.
  - misalign_o is cleared on the next pc_o update or on reset.
  - pc_o still takes the misaligned value.
- When undefined: port absent, no check logic.

Test Plan:
- Reset release, pc_ready_i=1, no redirects:
  - pc_valid_o=0 for one cycle, then pc_o=0x8000_0000.
  - pc_o then steps to 0x8000_0004 and 0x8000_0008 on successive cycles; epoch_o=0.
- In RUN, redir_valid_i=2'b11 with ch0=0x8000_1000 and ch1=0x8000_2000, pc_ready_i=0:
  - Next cycle pc_o=0x8000_1000, epoch_o=1.
- stall_i=1; ch1 redirect 0x8000_2000, then ch0 0x8000_3000, then ch1 0x8000_4000; stall_i=0:
  - pend_o=1 during the stall, pc_o held throughout.
  - After stall_i falls, pc_o=0x8000_3000 and epoch_o increments exactly once.
- pred_valid_i=1 with pred_pc_i=0x8000_0100 and fire:
  - Next pc_o=0x8000_0100.
  - Repeat with pc_ready_i=0: pc_o holds.
- pc_o=0xFFFF_FFFF_FFFF_FFFC, fire, no prediction:
  - pc_o=0; epoch unchanged.
- Async reset asserted mid-PEND:
  - pc_o=RESET_PC, pend_o=0 immediately.
  - After release the pending target is never applied.
  - With PC_GEN_MISALIGN_CHECK_EN, a redirect to 0x8000_0002 gives misalign_o=1 for that PC.
